rx: RTL and testbench
=====================

# rx

UART receiver: the receive half of the board's serial link, mirroring the odd-parity transmitter on the same line format. It samples the asynchronous serial input `Sin` and validates start, 8 data bits (LSB first), odd parity and stop. It presents each completed byte with error flags through a level-held `Receive` / `ReceiveAck` handshake. It feeds display/control logic in the receive-side top level.

## Interface
- `CLK_FREQUENCY`, 100_000_000, system clock rate in Hz.
- `BAUD_RATE`, 19_200, line bit rate in bits/s.
- `clk`  input  1  system clock; all state changes on rising edge.
- `Reset_n`  input  1  asynchronous, active-low reset.
- `Sin`  input  1  asynchronous serial line; idle high.
- `ReceiveAck`  input  1  consumer acknowledge; clears `Receive`.
- `Receive`  output  1  byte available; level-held until acknowledged.
- `Dout`  output  8  received byte; stable while `Receive`=1.
- `parityErr`  output  1  odd-parity check failed for the byte in `Dout`.
- `frameErr`  output  1  stop bit sampled low for the byte in `Dout`.
- `overrunErr`  output  1  a frame completed while `Receive` was still high.
- `busy`  output  1  high in every state except IDLE.

## Operation
- Constants:
  - `BIT_CNT = CLK_FREQUENCY / BAUD_RATE`, integer truncation (5208 at defaults).
  - `HALF_CNT = BIT_CNT / 2` (2604).
  - Timer width is `$clog2(BIT_CNT)`.
- Synchronizer: two flops on `Sin`, both reset to 1; the FSM sees only the second flop (`sin_s`).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `armed` sets when `sin_s`=1.
  - When `armed` and `sin_s`=0, go to START, clear the timer and the bit index.
- START: when the timer reaches `HALF_CNT-1`, sample `sin_s`.
  - 1: false start; go to IDLE, no outputs change.
  - 0: go to DATA, clear the timer.
- DATA: each time the timer reaches `BIT_CNT-1`:
  - Shift `sin_s` into bit 7 of the shift register (right shift, so LSB arrives first).
  - Increment the bit index and clear the timer.
  - After the 8th bit, go to PARITY.
- PARITY: at `BIT_CNT-1`, capture the parity bit; go to STOP.
- STOP: at `BIT_CNT-1`, sample the stop bit, then complete the frame:
  - `Dout` ← shift register.
  - `parityErr` ← ~(^{data, parity}).
  - `frameErr` ← ~stop.
  - `overrunErr` ← (`Receive` & ~`ReceiveAck`).
  - `Receive` ← 1.
  - Go to IDLE with `armed` cleared, so a low line (break or frame error) never re-triggers until `sin_s` returns high.
- Completion always overwrites `Dout` and the flags, even when an overrun occurs.
- Handshake:
  - `Receive` clears on the first edge where `ReceiveAck`=1 and no completion occurs that cycle.
  - Completion and ack in the same cycle: `Receive` stays 1 with the new data, and `overrunErr`=0.
  - `ReceiveAck` while `Receive`=0 is ignored.
- Reset (`Reset_n`=0, immediate):
  - State IDLE, `armed`=0, timer and index 0, sync flops 1.
  - `Dout`=8'h00; `Receive`, `parityErr`, `frameErr`, `overrunErr`, `busy` all 0.
  - Reset mid-frame abandons the frame with no completion.

## Timing
- t0 = first edge where `sin_s`=0 in IDLE with `armed` set; t0 is 2–3 clk after the pin's falling edge.
- Sample edges relative to t0:
  - start check: t0+HALF_CNT
  - data bit i (i=0..7): t0+HALF_CNT+(i+1)·BIT_CNT
  - parity: +9·BIT_CNT
  - stop: +10·BIT_CNT
- `Receive`, `Dout` and the flags are visible the cycle after the stop sample edge.
- `busy` rises the cycle after t0 and falls the cycle after the stop sample.
- Back-to-back frames: a start edge arriving half a bit after the stop sample is accepted, because `armed` is set by the stop-bit high level.

## Test plan
- Reset mid-frame: assert `Reset_n`=0 during DATA → all outputs 0 immediately; then a clean 0x07 frame is received normally.
- Good frame: send 0x41 with parity bit 1, stop 1 → `Receive`=1, `Dout`=8'h41, all errors 0; `ReceiveAck` pulse → `Receive`=0 next cycle.
- Parity error: send 0xFF with parity bit 0 → `Dout`=8'hFF, `parityErr`=1. Then send 0x07 with parity bit 0 → `parityErr`=0.
- Frame error and break:
  - Send 0x55 with stop bit 0 → `frameErr`=1.
  - Hold line low for 20 bit times → no second `Receive`.
  - Release line, then send 0x33 → it is received cleanly.
- Glitch: a low pulse of HALF_CNT/2 cycles → `busy` pulses, `Receive` stays 0, `Dout` unchanged.
- Overrun: send 0x12 then 0x34 back-to-back without ack → `Dout`=8'h34, `overrunErr`=1. Then ack with frame completion in the same cycle → `Receive` stays 1, `overrunErr`=0.

Source files
------------

// File: rtl/rx.sv
// UART receiver: 8 data bits LSB first, odd parity, one stop bit.
// Ports: clk, Reset_n, Sin, ReceiveAck in; Receive, Dout, error flags, busy out.
module rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       Sin,
  input  logic       ReceiveAck,
  output logic       Receive,
  output logic [7:0] Dout,
  output logic       parityErr,
  output logic       frameErr,
  output logic       overrunErr,
  output logic       busy
);

  localparam int BIT_CNT  = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int TW       = $clog2(BIT_CNT);

  localparam logic [TW-1:0] BIT_END  = TW'(BIT_CNT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(HALF_CNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          sin_m;
  logic          sin_s;
  logic          armed;
  logic [TW-1:0] tmr;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          par_bit;

  logic tmr_clr;
  logic shift_en;
  logic par_en;
  logic done;

  always_comb begin
    state_n  = state;
    tmr_clr  = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (armed && !sin_s) begin
          state_n = START;
          tmr_clr = 1'b1;
        end
      end
      START: begin
        // Mid-start check rejects glitches shorter than half a bit.
        if (tmr == HALF_END) begin
          tmr_clr = 1'b1;
          state_n = sin_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tmr == BIT_END) begin
          tmr_clr  = 1'b1;
          shift_en = 1'b1;
          if (idx == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (tmr == BIT_END) begin
          tmr_clr = 1'b1;
          par_en  = 1'b1;
          state_n = STOP;
        end
      end
      STOP: begin
        if (tmr == BIT_END) begin
          tmr_clr = 1'b1;
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sin_m      <= 1'b1;
      sin_s      <= 1'b1;
      state      <= IDLE;
      armed      <= 1'b0;
      tmr        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      Dout       <= '0;
      Receive    <= 1'b0;
      parityErr  <= 1'b0;
      frameErr   <= 1'b0;
      overrunErr <= 1'b0;
    end else begin
      sin_m <= Sin;
      sin_s <= sin_m;
      state <= state_n;

      if (tmr_clr || state == IDLE) tmr <= '0;
      else                          tmr <= tmr + 1'b1;

      // A low line after a frame must go high before it can start another.
      if (done)                     armed <= 1'b0;
      else if (state == IDLE && sin_s) armed <= 1'b1;

      if (state == IDLE) idx <= '0;
      else if (shift_en) idx <= idx + 3'd1;

      if (shift_en) shreg   <= {sin_s, shreg[7:1]};
      if (par_en)   par_bit <= sin_s;

      if (done) begin
        Dout       <= shreg;
        parityErr  <= ~(^{shreg, par_bit});
        frameErr   <= ~sin_s;
        overrunErr <= Receive & ~ReceiveAck;
        Receive    <= 1'b1;
      end else if (ReceiveAck) begin
        Receive <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rx.sv
// Testbench for rx: scoreboarded frames, errors, glitch, reset, overrun.
// Runs with a fast baud (16 clocks per bit) to keep the run short.
module tb_rx;

  localparam int CLKF = 1_600_000;
  localparam int BAUD = 100_000;
  localparam int BIT  = CLKF / BAUD;
  localparam int HALF = BIT / 2;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Sin = 1'b1;
  logic       ReceiveAck = 1'b0;
  logic       Receive;
  logic [7:0] Dout;
  logic       parityErr;
  logic       frameErr;
  logic       overrunErr;
  logic       busy;

  rx #(
    .CLK_FREQUENCY(CLKF),
    .BAUD_RATE    (BAUD)
  ) dut (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .Sin       (Sin),
    .ReceiveAck(ReceiveAck),
    .Receive   (Receive),
    .Dout      (Dout),
    .parityErr (parityErr),
    .frameErr  (frameErr),
    .overrunErr(overrunErr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       oe;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_d = 8'h00;

  function automatic logic [11:0] obs();
    return {Receive, Dout, parityErr, frameErr, overrunErr};
  endfunction

  function automatic logic [11:0] expv(input exp_t e);
    return {1'b1, e.d, e.pe, e.fe, e.oe};
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s, input logic oe);
    exp_t n;
    n.d  = d;
    n.pe = ~(^{d, p});
    n.fe = ~s;
    n.oe = oe;
    sb.push_back(n);
    last_d = d;
    @(negedge clk);
    Sin = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      Sin = d[i];
      repeat (BIT) @(negedge clk);
    end
    Sin = p;
    repeat (BIT) @(negedge clk);
    Sin = s;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4 * BIT; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL wait_done: busy=%b, want 0", busy);
    end
  endtask

  task automatic ack();
    @(negedge clk);
    ReceiveAck = 1'b1;
    @(negedge clk);
    ReceiveAck = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({obs(), busy} !== 13'h0) begin
      fails++;
      $display("FAIL reset: got %h want 0", {obs(), busy});
    end
    @(negedge clk);
    Reset_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic test_good();
    exp_t e;
    send_frame(8'h41, 1'b1, 1'b1, 1'b0);
    wait_done();
    e = sb.pop_front();
    tests++;
    if (obs() !== expv(e)) begin
      fails++;
      $display("FAIL good_41: got %h want %h", obs(), expv(e));
    end
    ack();
    tests++;
    if (Receive !== 1'b0) begin
      fails++;
      $display("FAIL good_ack: Receive=%b want 0", Receive);
    end
  endtask

  task automatic test_parity();
    exp_t e;
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    wait_done();
    e = sb.pop_front();
    tests++;
    if (obs() !== {1'b1, 8'hFF, 3'b100}) begin
      fails++;
      $display("FAIL parity_ff: got %h want %h", obs(), expv(e));
    end
    ack();
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    wait_done();
    e = sb.pop_front();
    tests++;
    if (obs() !== expv(e)) begin
      fails++;
      $display("FAIL parity_07: got %h want %h", obs(), expv(e));
    end
    ack();
  endtask

  task automatic test_frame();
    exp_t e;
    int   hits;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    wait_done();
    e = sb.pop_front();
    tests++;
    if (obs() !== {1'b1, 8'h55, 3'b010}) begin
      fails++;
      $display("FAIL frame_55: got %h want %h", obs(), expv(e));
    end
    ack();
    tests++;
    if (Receive !== 1'b0) begin
      fails++;
      $display("FAIL frame_ack: Receive=%b want 0", Receive);
    end
    hits = 0;
    for (int i = 0; i < 20 * BIT; i++) begin
      @(negedge clk);
      if (Receive || busy) hits++;
    end
    tests++;
    if (hits !== 0) begin
      fails++;
      $display("FAIL break: active cycles=%0d want 0", hits);
    end
    Sin = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send_frame(8'h33, 1'b1, 1'b1, 1'b0);
    wait_done();
    e = sb.pop_front();
    tests++;
    if (obs() !== expv(e)) begin
      fails++;
      $display("FAIL after_break: got %h want %h", obs(), expv(e));
    end
    ack();
  endtask

  task automatic test_glitch();
    bit saw_busy;
    bit saw_rx;
    saw_busy = 1'b0;
    saw_rx   = 1'b0;
    repeat (BIT) @(negedge clk);
    Sin = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    Sin = 1'b1;
    for (int i = 0; i < 2 * BIT; i++) begin
      @(negedge clk);
      saw_busy |= busy;
      saw_rx   |= Receive;
    end
    tests++;
    if (saw_busy !== 1'b1) begin
      fails++;
      $display("FAIL glitch_busy: saw=%b want 1", saw_busy);
    end
    tests++;
    if (saw_rx !== 1'b0) begin
      fails++;
      $display("FAIL glitch_rx: saw=%b want 0", saw_rx);
    end
    tests++;
    if (Dout !== last_d) begin
      fails++;
      $display("FAIL glitch_dout: got %h want %h", Dout, last_d);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    wait_done();
    e = sb.pop_front();
    tests++;
    if (obs() !== expv(e)) begin
      fails++;
      $display("FAIL pre_reset: got %h want %h", obs(), expv(e));
    end
    repeat (BIT) @(negedge clk);
    Sin = 1'b0;
    repeat (BIT) @(negedge clk);
    Sin = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy: busy=%b want 1", busy);
    end
    Reset_n = 1'b0;
    #1;
    tests++;
    if ({obs(), busy} !== 13'h0) begin
      fails++;
      $display("FAIL reset_mid: got %h want 0", {obs(), busy});
    end
    @(negedge clk);
    Reset_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    wait_done();
    e = sb.pop_front();
    tests++;
    if (obs() !== expv(e)) begin
      fails++;
      $display("FAIL post_reset: got %h want %h", obs(), expv(e));
    end
    ack();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    send_frame(8'h12, 1'b1, 1'b1, 1'b0);
    wait_done();
    e = sb.pop_front();
    tests++;
    if (obs() !== expv(e)) begin
      fails++;
      $display("FAIL b2b_12: got %h want %h", obs(), expv(e));
    end
    repeat (HALF) @(negedge clk);
    send_frame(8'h34, 1'b0, 1'b1, 1'b1);
    wait_done();
    e = sb.pop_front();
    tests++;
    if (obs() !== {1'b1, 8'h34, 3'b001}) begin
      fails++;
      $display("FAIL overrun_34: got %h want %h", obs(), expv(e));
    end
    repeat (HALF) @(negedge clk);
    fork
      send_frame(8'h56, 1'b1, 1'b1, 1'b0);
      begin
        // Sync flops put t0 three edges after the pin falls.
        @(negedge clk);
        repeat (2 + HALF + 10 * BIT) @(posedge clk);
        @(negedge clk);
        ReceiveAck = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ReceiveAck = 1'b0;
      end
    join
    e = sb.pop_front();
    tests++;
    if (obs() !== {1'b1, 8'h56, 3'b000}) begin
      fails++;
      $display("FAIL ack_same: got %h want %h", obs(), expv(e));
    end
    repeat (BIT) @(negedge clk);
    ack();
    tests++;
    if (Receive !== 1'b0) begin
      fails++;
      $display("FAIL final_ack: Receive=%b want 0", Receive);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_good();
    test_parity();
    test_frame();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
